branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 113 +++++++++++
 tb/tb_branch_resolve.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution in E: zero-cycle redirect on mispredict, E->M predictor update, saturating stats.
// A mispredict stalled in E redirects once; a mispredict leaving E squashes the next E instruction.
module branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [31:0]      pcD,
    input  logic             actual_takeE,
    input  logic [31:0]      branch_targetE,
    output logic             redirectE,
    output logic [31:0]      redirect_pcE,
    output logic             branchM,
    output logic             actual_takeM,
    output logic [31:0]      pcM,
    output logic             mispredM,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef enum logic {NORMAL, SQUASH} state_t;

    typedef struct packed {
        logic        branch;
        logic        predTake;
        logic [31:0] pc;
    } deReg_t;

    state_t state, stateNext;
    deReg_t deReg;
    logic   reportedE;
    logic   validE;
    logic   wrongDirE;
    logic   mispredE;

    assign validE       = deReg.branch && (state == NORMAL);
    assign wrongDirE    = deReg.predTake ^ actual_takeE;
    assign mispredE     = validE && wrongDirE && !reportedE;
    assign redirectE    = mispredE;
    assign redirect_pcE = actual_takeE ? branch_targetE : deReg.pc + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deReg <= '0;
        end else if (flushE) begin
            deReg <= '0;
        end else if (!stallE) begin
            deReg <= '{branch: branchD, predTake: pred_takeD, pc: pcD};
        end
    end

    // Remembers that the held E branch already redirected, so a long stall redirects only once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reportedE <= 1'b0;
        end else if (flushE || !stallE) begin
            reportedE <= 1'b0;
        end else if (mispredE) begin
            reportedE <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= NORMAL;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            NORMAL:  if (mispredE && !stallE) stateNext = SQUASH;
            SQUASH:  if (!stallE) stateNext = NORMAL;
            default: stateNext = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchM      <= 1'b0;
            actual_takeM <= 1'b0;
            pcM          <= '0;
            mispredM     <= 1'b0;
        end else begin
            branchM      <= validE && !stallE;
            actual_takeM <= actual_takeE;
            pcM          <= deReg.pc;
            mispredM     <= validE && wrongDirE && !stallE;
        end
    end

    // mispredM only counts alongside branchM, so mispred_cnt can never pass branch_cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (branchM && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (branchM && mispredM && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed and random checks of branch_resolve against an instruction-level model of the E/M slots.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallE, flushE, branchD, pred_takeD, actual_takeE;
    logic [31:0] pcD, branch_targetE;

    logic        redirectE, branchM, actual_takeM, mispredM;
    logic [31:0] redirect_pcE, pcM, branch_cnt, mispred_cnt;
    logic        redirect4, branchM4, actual_takeM4, mispredM4;
    logic [31:0] redirect_pc4, pcM4;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    int compared = 0;
    int mismatched = 0;

    // Instruction-level model: what sits in E, whether it is wrong-path, whether it already redirected.
    logic        eBr, ePred;
    logic [31:0] ePc;
    logic        eWrong, eRep;
    logic        mBr, mTake, mMis;
    logic [31:0] mPc;
    longint      cB, cM, cB4, cM4;

    always #5 clk = ~clk;

    branch_resolve #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .branchD(branchD),
        .pred_takeD(pred_takeD), .pcD(pcD), .actual_takeE(actual_takeE),
        .branch_targetE(branch_targetE), .redirectE(redirectE), .redirect_pcE(redirect_pcE),
        .branchM(branchM), .actual_takeM(actual_takeM), .pcM(pcM), .mispredM(mispredM),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .branchD(branchD),
        .pred_takeD(pred_takeD), .pcD(pcD), .actual_takeE(actual_takeE),
        .branch_targetE(branch_targetE), .redirectE(redirect4), .redirect_pcE(redirect_pc4),
        .branchM(branchM4), .actual_takeM(actual_takeM4), .pcM(pcM4), .mispredM(mispredM4),
        .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        eBr = 0; ePred = 0; ePc = 0; eWrong = 0; eRep = 0;
        mBr = 0; mTake = 0; mMis = 0; mPc = 0;
        cB = 0; cM = 0; cB4 = 0; cM4 = 0;
    endtask

    task automatic setD(input logic br, input logic pred, input logic [31:0] pc);
        branchD = br; pred_takeD = pred; pcD = pc;
    endtask

    task automatic doReset();
        stallE = 0; flushE = 0; setD(0, 0, 0); actual_takeE = 0; branch_targetE = 0;
        rst = 1'b0;
        #2;
        check("rst_redirect", {31'b0, redirectE}, 0);
        check("rst_branchM", {31'b0, branchM}, 0);
        check("rst_mispredM", {31'b0, mispredM}, 0);
        check("rst_pcM", pcM, 0);
        check("rst_branch_cnt", branch_cnt, 0);
        check("rst_mispred_cnt", mispred_cnt, 0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: compare outputs mid-cycle, advance the model by the rules, cross the edge.
    task automatic cycle();
        logic        expRed, nMBr, nMMis;
        logic [31:0] expPc;
        @(negedge clk);
        expRed = eBr && !eWrong && (ePred != actual_takeE) && !eRep;
        expPc  = actual_takeE ? branch_targetE : ePc + 32'd4;
        check("redirectE", {31'b0, redirectE}, {31'b0, expRed});
        check("redirect4", {31'b0, redirect4}, {31'b0, expRed});
        if (expRed) check("redirect_pcE", redirect_pcE, expPc);
        check("branchM", {31'b0, branchM}, {31'b0, mBr});
        check("mispredM", {31'b0, mispredM}, {31'b0, mMis});
        check("actual_takeM", {31'b0, actual_takeM}, {31'b0, mTake});
        check("pcM", pcM, mPc);
        check("branch_cnt", branch_cnt, 32'(cB));
        check("mispred_cnt", mispred_cnt, 32'(cM));
        check("branch_cnt4", {28'b0, branch_cnt4}, 32'(cB4));
        check("mispred_cnt4", {28'b0, mispred_cnt4}, 32'(cM4));

        nMBr  = eBr && !eWrong && !stallE;
        nMMis = nMBr && (ePred != actual_takeE);
        if (mBr) begin
            cB++;
            if (cB4 < 15) cB4++;
        end
        if (mBr && mMis) begin
            cM++;
            if (cM4 < 15) cM4++;
        end
        mTake = actual_takeE; mPc = ePc; mBr = nMBr; mMis = nMMis;
        eRep   = (flushE || !stallE) ? 1'b0 : (eRep || expRed);
        eWrong = stallE ? eWrong : expRed;
        if (flushE) begin
            eBr = 0; ePred = 0; ePc = 0;
        end else if (!stallE) begin
            eBr = branchD; ePred = pred_takeD; ePc = pcD;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        doReset();

        // Correctly predicted taken branch
        setD(1, 1, 32'h100); cycle();
        setD(0, 0, 0); actual_takeE = 1; branch_targetE = 32'h500; cycle();
        cycles(2);
        check("req031_branch_cnt", branch_cnt, 1);
        check("req031_mispred_cnt", mispred_cnt, 0);

        // Predicted not-taken, actually taken; the following instruction is wrong-path
        setD(1, 0, 32'h200); cycle();
        setD(1, 0, 32'h204); actual_takeE = 1; branch_targetE = 32'h400; cycle();
        setD(0, 0, 0); cycle();
        cycles(2);
        check("req032_mispred_cnt", mispred_cnt, 1);

        // Mispredict held in E by a 3-cycle stall
        setD(1, 1, 32'h300); actual_takeE = 0; cycle();
        setD(0, 0, 0); stallE = 1; cycles(3);
        stallE = 0; cycles(3);

        // Flush beats stall while a branch waits in D
        setD(1, 0, 32'h500); actual_takeE = 1; stallE = 1; flushE = 1; cycle();
        setD(0, 0, 0); stallE = 0; flushE = 0; cycles(3);

        // Fall-through PC wraps at the top of the address space
        setD(1, 1, 32'hFFFF_FFFC); actual_takeE = 0; cycle();
        setD(0, 0, 0); cycles(3);

        // 17 mispredicts saturate the narrow counters
        doReset();
        actual_takeE = 1; branch_targetE = 32'h800;
        for (int i = 0; i < 17; i++) begin
            setD(1, 0, 32'h1000 + 32'(i * 8)); cycle();
            setD(0, 0, 0); cycle();
        end
        cycles(3);
        check("req035_branch_cnt4", {28'b0, branch_cnt4}, 15);
        check("req035_mispred_cnt4", {28'b0, mispred_cnt4}, 15);
        check("req035_branch_cnt", branch_cnt, 17);

        // Reset during squash, then a fresh mispredict must redirect
        setD(1, 0, 32'h600); actual_takeE = 1; cycle();
        setD(1, 1, 32'h604); cycle();
        doReset();
        setD(1, 1, 32'h700); cycle();
        setD(0, 0, 0); actual_takeE = 0; cycle();
        cycles(2);
        check("req036_mispred_cnt", mispred_cnt, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            stallE = ($urandom_range(0, 3) == 0);
            flushE = ($urandom_range(0, 9) == 0);
            branchD = $urandom_range(0, 1);
            pred_takeD = $urandom_range(0, 1);
            pcD = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} & 32'hFFFF_FFFC;
            actual_takeE = $urandom_range(0, 1);
            branch_targetE = {$urandom} & 32'hFFFF_FFFC;
            cycle();
        end
        stallE = 0; flushE = 0; setD(0, 0, 0);
        cycles(3);
        check("final_ordering", {31'b0, (mispred_cnt <= branch_cnt)}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
